// File: rtl/tr_seq_pkg.sv
// Shared state type, timer widths and output-decode helpers for the T/R sequencer.
package tr_seq_pkg;

    localparam int unsigned TR_MS_W  = 16;
    localparam int unsigned TR_CYC_W = 8;

    typedef enum logic [2:0] {
        RX      = 3'd0,
        RLY_ON  = 3'd1,
        PA_ON   = 3'd2,
        TX      = 3'd3,
        HANG    = 3'd4,
        PA_OFF  = 3'd5,
        RLY_OFF = 3'd6
    } tr_state_t;

    // Relay is closed in every state except RX.
    function automatic logic relay_closed(input tr_state_t s);
        return s != RX;
    endfunction

    // PA bias is applied once the relay has settled and until shutdown begins.
    function automatic logic pa_biased(input tr_state_t s);
        return (s == PA_ON) || (s == TX) || (s == HANG);
    endfunction

    // PTT is reported to the host while transmitting or hanging in CW.
    function automatic logic ptt_reported(input tr_state_t s);
        return (s == TX) || (s == HANG);
    endfunction

endpackage

// File: rtl/tr_seq_timer.sv
// Loadable down-counter that saturates at zero; a load always wins over a count.
module tr_seq_timer
    import tr_seq_pkg::*;
#(
    parameter int unsigned W = TR_MS_W
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         ce,
    input  logic         load,
    input  logic [W-1:0] load_val,
    output logic         zero
);

    logic [W-1:0] cnt;

    // Load on state entry, otherwise count down on each enable and stop at zero.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt <= '0;
        end else if (load) begin
            cnt <= load_val;
        end else if (ce && (cnt != '0)) begin
            cnt <= cnt - W'(1);
        end
    end

    assign zero = (cnt == '0);

endmodule

// File: rtl/tr_sequencer.sv
// T/R relay and PA bias sequencer: arbitrates PTT sources and keys/unkeys the
// relay and PA in a timed order, with CW hang, TX inhibit abort and a key-down
// timeout that locks out further keying until all PTT sources are released.
module tr_sequencer
    import tr_seq_pkg::*;
#(
    parameter int unsigned RLY_SETTLE_MS = 3,
    parameter int unsigned PA_SETTLE_CYC = 25,
    parameter int unsigned TX_TIMEOUT_MS = 0
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       millisec_pulse,
    input  logic       run,
    input  logic       int_ptt,
    input  logic       cw_keydown,
    input  logic       ext_ptt,
    input  logic       ext_txinhibit,
    input  logic       vna,
    input  logic       pa_enable,
    input  logic       tr_disable,
    input  logic [9:0] cw_hang_time,
    output logic       tx_on,
    output logic       tx_power_on,
    output logic       pa_tr,
    output logic       pa_en,
    output logic       ptt_resp,
    output logic       lockout
);

    localparam logic [TR_MS_W-1:0]  RLY_LOAD = TR_MS_W'(RLY_SETTLE_MS);
    localparam logic [TR_CYC_W-1:0] PA_LOAD  = TR_CYC_W'(PA_SETTLE_CYC);
    localparam logic [TR_MS_W-1:0]  TO_LOAD  = TR_MS_W'(TX_TIMEOUT_MS);
    localparam logic                TO_EN    = (TX_TIMEOUT_MS != 0);

    tr_state_t state;
    tr_state_t state_next;

    logic                any_ptt;
    logic                req;
    logic                timeout;
    logic                abort;
    logic                cw_last;

    logic                ms_load;
    logic [TR_MS_W-1:0]  ms_val;
    logic                ms_zero;
    logic                cyc_load;
    logic [TR_CYC_W-1:0] cyc_val;
    logic                cyc_zero;

    assign any_ptt = int_ptt | cw_keydown | ext_ptt;
    assign req     = any_ptt & run & ~ext_txinhibit & ~lockout;
    // The ms timer doubles as the TX timeout counter, so only its zero in TX counts.
    assign timeout = TO_EN & (state == TX) & ms_zero;
    assign abort   = ext_txinhibit | ~run | timeout;

    // Millisecond timer: relay settle, TX timeout and CW hang.
    tr_seq_timer #(
        .W (TR_MS_W)
    ) u_ms_timer (
        .clk      (clk),
        .rst      (rst),
        .ce       (millisec_pulse),
        .load     (ms_load),
        .load_val (ms_val),
        .zero     (ms_zero)
    );

    // Clock-cycle timer: PA bias settle on the way up and down.
    tr_seq_timer #(
        .W (TR_CYC_W)
    ) u_cyc_timer (
        .clk      (clk),
        .rst      (rst),
        .ce       (1'b1),
        .load     (cyc_load),
        .load_val (cyc_val),
        .zero     (cyc_zero)
    );

    // State register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= RX;
        end else begin
            state <= state_next;
        end
    end

    // Next state and timer loads; abort is tested before req wherever both apply.
    always_comb begin
        state_next = state;
        ms_load    = 1'b0;
        ms_val     = '0;
        cyc_load   = 1'b0;
        cyc_val    = '0;
        case (state)
            RX: begin
                if (req) begin
                    state_next = RLY_ON;
                    ms_load    = 1'b1;
                    ms_val     = RLY_LOAD;
                end
            end
            RLY_ON: begin
                if (abort) begin
                    state_next = RLY_OFF;
                    ms_load    = 1'b1;
                    ms_val     = RLY_LOAD;
                end else if (ms_zero) begin
                    state_next = PA_ON;
                    cyc_load   = 1'b1;
                    cyc_val    = PA_LOAD;
                end
            end
            PA_ON: begin
                if (abort) begin
                    state_next = PA_OFF;
                    cyc_load   = 1'b1;
                    cyc_val    = PA_LOAD;
                end else if (cyc_zero) begin
                    state_next = TX;
                    ms_load    = 1'b1;
                    ms_val     = TO_LOAD;
                end
            end
            TX: begin
                if (abort) begin
                    state_next = PA_OFF;
                    cyc_load   = 1'b1;
                    cyc_val    = PA_LOAD;
                end else if (!req) begin
                    if (cw_last && (cw_hang_time != '0)) begin
                        state_next = HANG;
                        ms_load    = 1'b1;
                        ms_val     = TR_MS_W'(cw_hang_time);
                    end else begin
                        state_next = PA_OFF;
                        cyc_load   = 1'b1;
                        cyc_val    = PA_LOAD;
                    end
                end
            end
            HANG: begin
                if (abort) begin
                    state_next = PA_OFF;
                    cyc_load   = 1'b1;
                    cyc_val    = PA_LOAD;
                end else if (req) begin
                    state_next = TX;
                    ms_load    = 1'b1;
                    ms_val     = TO_LOAD;
                end else if (ms_zero) begin
                    state_next = PA_OFF;
                    cyc_load   = 1'b1;
                    cyc_val    = PA_LOAD;
                end
            end
            PA_OFF: begin
                if (cyc_zero) begin
                    state_next = RLY_OFF;
                    ms_load    = 1'b1;
                    ms_val     = RLY_LOAD;
                end
            end
            RLY_OFF: begin
                if (ms_zero) begin
                    state_next = RX;
                end
            end
            default: begin
                state_next = RX;
            end
        endcase
    end

    // Remember whether the keyer was holding TX so its release can enter HANG.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cw_last <= 1'b0;
        end else if (state == TX) begin
            cw_last <= cw_keydown;
        end else if (state == RX) begin
            cw_last <= 1'b0;
        end
    end

    // Timeout lockout: set on TX expiry, cleared only once back in RX with all PTT released.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            lockout <= 1'b0;
        end else if (timeout) begin
            lockout <= 1'b1;
        end else if ((state == RX) && !any_ptt) begin
            lockout <= 1'b0;
        end
    end

    assign tx_power_on = relay_closed(state);
    assign pa_tr       = relay_closed(state) & ~vna & (pa_enable | ~tr_disable);
    assign pa_en       = pa_biased(state) & ~vna & pa_enable;
    assign tx_on       = (state == TX);
    assign ptt_resp    = ptt_reported(state);

endmodule

// File: tb/tb_tr_sequencer.sv
// Self-checking bench for tr_sequencer: a timeline model predicts the edge at
// which each keying phase begins from the settle/hang/timeout rules and the
// bench's own millisecond strobe schedule, and every cycle is compared.
module tb_tr_sequencer;

    localparam int unsigned RLY_MS = 3;
    localparam int unsigned PA_CYC = 25;
    localparam int unsigned TO_MS  = 100;
    localparam int unsigned MSP    = 20;   // clocks per bench millisecond

    localparam int PH_IDLE    = 0;
    localparam int PH_RELAY   = 1;
    localparam int PH_BIAS    = 2;
    localparam int PH_TX      = 3;
    localparam int PH_HANG    = 4;
    localparam int PH_UNBIAS  = 5;
    localparam int PH_UNRELAY = 6;

    localparam int SRC_INT = 0;
    localparam int SRC_CW  = 1;
    localparam int SRC_EXT = 2;

    logic       clk = 1'b0;
    logic       rst;
    logic       millisec_pulse = 1'b0;
    logic       run;
    logic       int_ptt;
    logic       cw_keydown;
    logic       ext_ptt;
    logic       ext_txinhibit;
    logic       vna;
    logic       pa_enable;
    logic       tr_disable;
    logic [9:0] cw_hang_time;
    logic       tx_on;
    logic       tx_power_on;
    logic       pa_tr;
    logic       pa_en;
    logic       ptt_resp;
    logic       lockout;

    int unsigned edge_n   = 0;
    int unsigned ms_phase = 2;
    int unsigned n_checks = 0;
    int unsigned n_err    = 0;
    logic        exp_lock = 1'b0;

    tr_sequencer #(
        .RLY_SETTLE_MS (RLY_MS),
        .PA_SETTLE_CYC (PA_CYC),
        .TX_TIMEOUT_MS (TO_MS)
    ) dut (
        .clk            (clk),
        .rst            (rst),
        .millisec_pulse (millisec_pulse),
        .run            (run),
        .int_ptt        (int_ptt),
        .cw_keydown     (cw_keydown),
        .ext_ptt        (ext_ptt),
        .ext_txinhibit  (ext_txinhibit),
        .vna            (vna),
        .pa_enable      (pa_enable),
        .tr_disable     (tr_disable),
        .cw_hang_time   (cw_hang_time),
        .tx_on          (tx_on),
        .tx_power_on    (tx_power_on),
        .pa_tr          (pa_tr),
        .pa_en          (pa_en),
        .ptt_resp       (ptt_resp),
        .lockout        (lockout)
    );

    always #5 clk = ~clk;

    always @(posedge clk) edge_n <= edge_n + 1;

    // Strobe is sampled high at every edge j with j % MSP == ms_phase.
    initial begin
        forever begin
            @(posedge clk);
            #1;
            millisec_pulse = (((edge_n + 1) % MSP) == ms_phase);
        end
    end

    initial begin
        #900_000;
        $display("FAIL watchdog: bench did not reach its summary, checks=%0d", n_checks);
        $fatal(1, "watchdog expired");
    end

    function automatic int unsigned next_pulse(input int unsigned e);
        int unsigned p;
        p = e + 1;
        return p + ((ms_phase + MSP - (p % MSP)) % MSP);
    endfunction

    // Edge at which a state entered at edge e with an n-ms timer is left.
    function automatic int unsigned ms_exit(input int unsigned e, input int unsigned n);
        int unsigned j;
        j = e;
        for (int unsigned i = 0; i < n; i++) j = next_pulse(j);
        return j + 1;
    endfunction

    function automatic logic [5:0] obs_vec();
        return {tx_on, tx_power_on, pa_tr, pa_en, ptt_resp, lockout};
    endfunction

    function automatic logic [5:0] exp_vec(input int ph);
        logic relay, bias, txing, resp;
        relay = (ph != PH_IDLE);
        bias  = (ph == PH_BIAS) || (ph == PH_TX) || (ph == PH_HANG);
        txing = (ph == PH_TX);
        resp  = (ph == PH_TX) || (ph == PH_HANG);
        return {txing, relay, relay & ~vna & (pa_enable | ~tr_disable),
                bias & ~vna & pa_enable, resp, exp_lock};
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk_vec(input string tag, input int ph);
        logic [5:0] o, e;
        o = obs_vec();
        e = exp_vec(ph);
        n_checks++;
        assert (o === e) else begin
            n_err++;
            $error("FAIL %s @edge %0d: {tx_on,tx_power_on,pa_tr,pa_en,ptt_resp,lockout} observed %b expected %b",
                   tag, edge_n, o, e);
        end
    endtask

    // Advance to edge 'last', checking every edge against phase ph.
    task automatic span(input string tag, input int ph, input int unsigned last);
        while (edge_n < last) begin
            tick();
            chk_vec(tag, ph);
        end
    endtask

    task automatic set_src(input int src, input logic val);
        case (src)
            SRC_INT: int_ptt    = val;
            SRC_CW:  cw_keydown = val;
            default: ext_ptt    = val;
        endcase
    endtask

    // Request was raised at the current sample; follow relay and bias settle into TX.
    task automatic key_up(output int unsigned e_tx);
        int unsigned e_rly, e_pa;
        e_rly = edge_n + 1;
        e_pa  = ms_exit(e_rly, RLY_MS);
        e_tx  = e_pa + PA_CYC + 1;
        span("relay settle", PH_RELAY, e_pa - 1);
        span("pa settle", PH_BIAS, e_tx - 1);
        span("tx entry", PH_TX, e_tx);
    endtask

    task automatic shut_relay(input int unsigned e_roff);
        int unsigned e_rx;
        e_rx = ms_exit(e_roff, RLY_MS);
        span("relay release", PH_UNRELAY, e_rx - 1);
        span("back to rx", PH_IDLE, e_rx);
    endtask

    task automatic shut_down(input int unsigned e_off);
        span("pa release", PH_UNBIAS, e_off + PA_CYC);
        shut_relay(e_off + PA_CYC + 1);
    endtask

    task automatic full_cycle(input int src, input int unsigned hold);
        int unsigned e_tx;
        set_src(src, 1'b1);
        key_up(e_tx);
        span("tx hold", PH_TX, e_tx + hold - 1);
        set_src(src, 1'b0);
        shut_down(e_tx + hold);
    endtask

    initial begin
        int unsigned e_tx, e_rly, e_pa, e_h, e_h2, e_x, s, r;
        int          src;
        logic [2:0]  combos [6];

        combos = '{3'b010, 3'b001, 3'b000, 3'b110, 3'b011, 3'b101};
        ms_phase = $urandom_range(MSP - 1, 2);

        rst = 1'b1;
        run = 1'b1;
        int_ptt = 1'b0;
        cw_keydown = 1'b0;
        ext_ptt = 1'b0;
        ext_txinhibit = 1'b0;
        vna = 1'b0;
        pa_enable = 1'b1;
        tr_disable = 1'b0;
        cw_hang_time = 10'd10;

        // Reset state.
        repeat (3) tick();
        chk_vec("reset", PH_IDLE);
        rst = 1'b0;
        span("idle after reset", PH_IDLE, edge_n + 4);

        // Host PTT keying with nominal settings; int_ptt release never hangs.
        full_cycle(SRC_INT, $urandom_range(150, 20));
        span("idle", PH_IDLE, edge_n + 5);

        // VNA masks relay and bias, timing otherwise unchanged.
        vna = 1'b1;
        full_cycle(SRC_INT, 40);
        vna = 1'b0;
        span("idle", PH_IDLE, edge_n + 5);

        // CW hang: release enters HANG, rekey returns to TX, second hang expires.
        cw_hang_time = 10'd10;
        cw_keydown = 1'b1;
        key_up(e_tx);
        span("cw tx", PH_TX, e_tx + 30);
        cw_keydown = 1'b0;
        e_h = e_tx + 31;
        r = $urandom_range(6 * MSP, 4 * MSP);
        span("cw hang", PH_HANG, e_h + r - 1);
        cw_keydown = 1'b1;
        span("cw rekey", PH_TX, e_h + r + 20);
        cw_keydown = 1'b0;
        e_h2 = e_h + r + 21;
        e_x = ms_exit(e_h2, 10);
        span("cw hang expiry", PH_HANG, e_x - 1);
        shut_down(e_x);
        span("idle", PH_IDLE, edge_n + 5);

        // TX inhibit pulse during PA settle; held int_ptt restarts from RX,
        // then is dropped during relay settle so TX lasts exactly one cycle.
        int_ptt = 1'b1;
        e_rly = edge_n + 1;
        e_pa = ms_exit(e_rly, RLY_MS);
        span("inhibit relay", PH_RELAY, e_pa - 1);
        s = e_pa + $urandom_range(PA_CYC - 1, 0);
        span("inhibit bias", PH_BIAS, s);
        ext_txinhibit = 1'b1;
        span("inhibit abort", PH_UNBIAS, s + 1);
        ext_txinhibit = 1'b0;
        shut_down(s + 1);
        e_rly = edge_n + 1;
        e_pa = ms_exit(e_rly, RLY_MS);
        span("restart relay", PH_RELAY, e_rly);
        int_ptt = 1'b0;
        span("dropped req relay", PH_RELAY, e_pa - 1);
        span("dropped req bias", PH_BIAS, e_pa + PA_CYC);
        span("dropped req tx", PH_TX, e_pa + PA_CYC + 1);
        shut_down(e_pa + PA_CYC + 2);
        span("idle", PH_IDLE, edge_n + 5);

        // run dropped during relay settle goes straight to relay release.
        int_ptt = 1'b1;
        e_rly = edge_n + 1;
        e_pa = ms_exit(e_rly, RLY_MS);
        s = e_rly + $urandom_range(e_pa - e_rly - 2, 0);
        span("run drop relay", PH_RELAY, s);
        run = 1'b0;
        int_ptt = 1'b0;
        shut_relay(s + 1);
        run = 1'b1;
        span("idle", PH_IDLE, edge_n + 5);

        // Source / mask combinations with random source and hold.
        for (int i = 0; i < 6; i++) begin
            {vna, pa_enable, tr_disable} = combos[i];
            src = $urandom_range(2, 0);
            cw_hang_time = (src == SRC_CW) ? 10'd0 : 10'($urandom_range(20, 1));
            span("idle", PH_IDLE, edge_n + $urandom_range(15, 1));
            full_cycle(src, $urandom_range(120, 2));
        end
        vna = 1'b0;
        pa_enable = 1'b1;
        tr_disable = 1'b0;
        span("idle", PH_IDLE, edge_n + 5);

        // Key-down timeout with ext_ptt held, lockout until ptt released.
        ext_ptt = 1'b1;
        key_up(e_tx);
        e_x = ms_exit(e_tx, TO_MS);
        span("timeout tx", PH_TX, e_x - 1);
        exp_lock = 1'b1;
        shut_down(e_x);
        span("locked out", PH_IDLE, edge_n + 30);
        ext_ptt = 1'b0;
        exp_lock = 1'b0;
        span("lockout clear", PH_IDLE, edge_n + 1);
        full_cycle(SRC_EXT, 10);
        span("idle", PH_IDLE, edge_n + 5);

        // Reset asserted mid-TX drops everything at once, then resequences.
        int_ptt = 1'b1;
        key_up(e_tx);
        span("pre reset tx", PH_TX, e_tx + 10);
        rst = 1'b1;
        #1;
        chk_vec("async reset", PH_IDLE);
        span("held in reset", PH_IDLE, edge_n + 3);
        rst = 1'b0;
        key_up(e_tx);
        span("post reset tx", PH_TX, e_tx + 15);
        int_ptt = 1'b0;
        shut_down(e_tx + 16);
        span("idle", PH_IDLE, edge_n + 5);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
        $finish;
    end

endmodule
